// File: rtl/accum_pkg.sv
// Shared helpers for the streaming tree accumulator: tree geometry and the
// saturating/wrapping accumulate step.
package accum_pkg;

    localparam int SAT_W = 64;

    function automatic int tree_depth(input int n);
        int d;
        d = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) d = k + 1;
        end
        return d;
    endfunction

    function automatic int level_nodes(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

    // Returns {ovf, result}; operands must already lie in the signed w-bit range,
    // so an out-of-range exact sum is the same as the top two bits of a w+1 sum differing.
    function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                               input logic signed [SAT_W-1:0] b,
                                               input int w,
                                               input bit sat);
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        logic                    ovf;
        sum   = a + b;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        ovf   = (sum > max_v) || (sum < min_v);
        if (!ovf)
            res = sum;
        else if (sat)
            res = (sum > max_v) ? max_v : min_v;
        else
            res = (sum <<< (SAT_W - w)) >>> (SAT_W - w);
        return {ovf, res};
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the lane adder tree: adjacent pairs are summed one bit
// wider, an odd leftover lane is sign-extended and registered unchanged.
module adder_tree_level #(
    parameter  int IN_W  = 8,
    parameter  int N_IN  = 2,
    localparam int N_OUT = (N_IN + 1) / 2
) (
    input  logic                        clk,
    input  logic [N_IN-1:0][IN_W-1:0]   i_data,
    output logic [N_OUT-1:0][IN_W:0]    o_data
);

    logic [N_OUT-1:0][IN_W:0] r_sum;

    // Data registers carry no reset; validity travels in the sideband pipe.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_IN / 2; k++) begin
            r_sum[k] <= {i_data[2*k][IN_W-1], i_data[2*k]}
                      + {i_data[2*k+1][IN_W-1], i_data[2*k+1]};
        end
        if (N_IN % 2 == 1) begin
            r_sum[N_OUT-1] <= {i_data[N_IN-1][IN_W-1], i_data[N_IN-1]};
        end
    end

    assign o_data = r_sum;

endmodule

// File: rtl/streaming_tree_accumulator.sv
// Sums NO_IN signed lanes per beat through a registered adder tree, then accumulates
// beats between first/last into one saturating (or wrapping) frame result.
module streaming_tree_accumulator
    import accum_pkg::*;
#(
    parameter int IN_BITWIDTH  = 8,
    parameter int OUT_BITWIDTH = 16,
    parameter int NO_IN        = 6,
    parameter bit SATURATE     = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                vld_in,
    input  logic                                first_in,
    input  logic                                last_in,
    input  logic [NO_IN-1:0][IN_BITWIDTH-1:0]   data_in,
    output logic                                vld_out,
    output logic [OUT_BITWIDTH-1:0]             data_out,
    output logic                                ovf_out
);

    localparam int D = tree_depth(NO_IN);

    if (NO_IN < 1) begin : g_lanes_check
        $error("streaming_tree_accumulator: NO_IN must be at least 1");
    end
    if (IN_BITWIDTH + D > OUT_BITWIDTH) begin : g_width_check
        $error("streaming_tree_accumulator: IN_BITWIDTH + tree depth exceeds OUT_BITWIDTH");
    end

    logic signed [OUT_BITWIDTH-1:0] w_tree_s;
    logic                           w_t_vld;
    logic                           w_t_first;
    logic                           w_t_last;

    if (D == 0) begin : g_notree
        assign w_tree_s  = OUT_BITWIDTH'($signed(data_in[0]));
        assign w_t_vld   = vld_in;
        assign w_t_first = vld_in & first_in;
        assign w_t_last  = vld_in & last_in;
    end else begin : g_tree
        for (genvar l = 0; l < D; l++) begin : g_lvl
            localparam int LW = IN_BITWIDTH + l;
            localparam int LN = level_nodes(NO_IN, l);
            localparam int LO = level_nodes(NO_IN, l + 1);

            logic [LN-1:0][LW-1:0] w_in;
            logic [LO-1:0][LW:0]   w_out;

            if (l == 0) begin : g_src
                assign w_in = data_in;
            end else begin : g_src
                assign w_in = g_lvl[l-1].w_out;
            end

            adder_tree_level #(
                .IN_W (LW),
                .N_IN (LN)
            ) u_level (
                .clk    (clk),
                .i_data (w_in),
                .o_data (w_out)
            );
        end

        assign w_tree_s = OUT_BITWIDTH'($signed(g_lvl[D-1].w_out[0]));

        logic [D-1:0] r_vld_sr;
        logic [D-1:0] r_first_sr;
        logic [D-1:0] r_last_sr;

        // first/last are qualified on entry so bubbles never carry frame markers.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld_sr   <= '0;
                r_first_sr <= '0;
                r_last_sr  <= '0;
            end else begin
                r_vld_sr[0]   <= vld_in;
                r_first_sr[0] <= vld_in & first_in;
                r_last_sr[0]  <= vld_in & last_in;
                for (int i = 1; i < D; i++) begin
                    r_vld_sr[i]   <= r_vld_sr[i-1];
                    r_first_sr[i] <= r_first_sr[i-1];
                    r_last_sr[i]  <= r_last_sr[i-1];
                end
            end
        end

        assign w_t_vld   = r_vld_sr[D-1];
        assign w_t_first = r_first_sr[D-1];
        assign w_t_last  = r_last_sr[D-1];
    end

    logic signed [OUT_BITWIDTH-1:0] r_acc;
    logic                           r_ovf;
    logic                           r_vld_out;
    logic [OUT_BITWIDTH-1:0]        r_data_out;
    logic                           r_ovf_out;

    logic [SAT_W:0]                 w_sat;
    logic [SAT_W-1:OUT_BITWIDTH]    w_unused_sat_hi;
    logic signed [OUT_BITWIDTH-1:0] w_acc_next;
    logic                           w_ovf_next;

    assign w_sat           = sat_add(SAT_W'(r_acc), SAT_W'(w_tree_s), OUT_BITWIDTH, SATURATE);
    assign w_unused_sat_hi = w_sat[SAT_W-1:OUT_BITWIDTH];

    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf;
        if (w_t_first) begin
            w_acc_next = w_tree_s;
            w_ovf_next = 1'b0;
        end else begin
            w_acc_next = w_sat[OUT_BITWIDTH-1:0];
            w_ovf_next = r_ovf | w_sat[SAT_W];
        end
    end

    // A last beat publishes the frame and leaves the accumulator empty for whatever follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_vld_out  <= 1'b0;
            r_data_out <= '0;
            r_ovf_out  <= 1'b0;
        end else begin
            r_vld_out <= 1'b0;
            if (w_t_vld) begin
                if (w_t_last) begin
                    r_data_out <= w_acc_next;
                    r_ovf_out  <= w_ovf_next;
                    r_vld_out  <= 1'b1;
                    r_acc      <= '0;
                    r_ovf      <= 1'b0;
                end else begin
                    r_acc <= w_acc_next;
                    r_ovf <= w_ovf_next;
                end
            end
        end
    end

    assign vld_out  = r_vld_out;
    assign data_out = r_data_out;
    assign ovf_out  = r_ovf_out;

endmodule

// File: tb/tb_streaming_tree_accumulator.sv
// Bench for streaming_tree_accumulator: five builds share one beat stream, each with
// its own frame-sum model and expected queue checked on every output pulse.
module tb_streaming_tree_accumulator;

    logic            clk = 1'b0;
    logic            reset;
    logic            vld_in;
    logic            first_in;
    logic            last_in;
    logic [5:0][7:0] data_in;

    logic        v0, v1, v2, v3, v4;
    logic        o0, o1, o2, o3, o4;
    logic [15:0] d0, d3, d4;
    logic [11:0] d1, d2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Per-build configuration: lanes, result width, saturate, tree depth.
    int cfg_nl[5]  = '{6, 6, 6, 1, 5};
    int cfg_w[5]   = '{16, 12, 12, 16, 16};
    bit cfg_sat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int cfg_d[5]   = '{3, 3, 3, 0, 3};

    longint m_acc[5];
    bit     m_ovf[5];

    // Entry layout: {due cycle[30:0], ovf, data[31:0]}.
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [63:0] exp_q2[$];
    logic [63:0] exp_q3[$];
    logic [63:0] exp_q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    streaming_tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(16), .NO_IN(6), .SATURATE(1'b1)) u_dut (
        .clk(clk), .reset(reset), .vld_in(vld_in), .first_in(first_in), .last_in(last_in),
        .data_in(data_in), .vld_out(v0), .data_out(d0), .ovf_out(o0));

    streaming_tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(12), .NO_IN(6), .SATURATE(1'b1)) u_sat12 (
        .clk(clk), .reset(reset), .vld_in(vld_in), .first_in(first_in), .last_in(last_in),
        .data_in(data_in), .vld_out(v1), .data_out(d1), .ovf_out(o1));

    streaming_tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(12), .NO_IN(6), .SATURATE(1'b0)) u_wrap12 (
        .clk(clk), .reset(reset), .vld_in(vld_in), .first_in(first_in), .last_in(last_in),
        .data_in(data_in), .vld_out(v2), .data_out(d2), .ovf_out(o2));

    streaming_tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(16), .NO_IN(1), .SATURATE(1'b1)) u_n1 (
        .clk(clk), .reset(reset), .vld_in(vld_in), .first_in(first_in), .last_in(last_in),
        .data_in(data_in[0:0]), .vld_out(v3), .data_out(d3), .ovf_out(o3));

    streaming_tree_accumulator #(.IN_BITWIDTH(8), .OUT_BITWIDTH(16), .NO_IN(5), .SATURATE(1'b1)) u_n5 (
        .clk(clk), .reset(reset), .vld_in(vld_in), .first_in(first_in), .last_in(last_in),
        .data_in(data_in[4:0]), .vld_out(v4), .data_out(d4), .ovf_out(o4));

    // Reference model -------------------------------------------------------------

    function automatic longint wrap_to(input longint v, input int w);
        longint m;
        longint h;
        longint r;
        m = longint'(1) << w;
        h = m / 2;
        r = (v + h) % m;
        if (r < 0) r = r + m;
        return r - h;
    endfunction

    task automatic push_exp(input int idx, input logic [63:0] e);
        case (idx)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            2: exp_q2.push_back(e);
            3: exp_q3.push_back(e);
            default: exp_q4.push_back(e);
        endcase
    endtask

    task automatic model_beat(input bit f, input bit l, input logic [5:0][7:0] ln);
        for (int c = 0; c < 5; c++) begin
            longint s;
            longint t;
            longint hi;
            longint lo;
            logic [30:0] ec;
            logic [31:0] ed;
            s = 0;
            for (int k = 0; k < cfg_nl[c]; k++) s = s + longint'($signed(ln[k]));
            hi = (longint'(1) << (cfg_w[c] - 1)) - 1;
            lo = -hi - 1;
            if (f) begin
                m_acc[c] = s;
                m_ovf[c] = 1'b0;
            end else begin
                t = m_acc[c] + s;
                if (t > hi || t < lo) begin
                    m_ovf[c] = 1'b1;
                    if (cfg_sat[c]) m_acc[c] = (t > hi) ? hi : lo;
                    else            m_acc[c] = wrap_to(t, cfg_w[c]);
                end else begin
                    m_acc[c] = t;
                end
            end
            if (l) begin
                ec = 31'(cyc + 1 + cfg_d[c]);
                ed = 32'(m_acc[c]);
                push_exp(c, {ec, m_ovf[c], ed});
                m_acc[c] = 0;
                m_ovf[c] = 1'b0;
            end
        end
    endtask

    // Drivers ---------------------------------------------------------------------

    task automatic drive(input bit v, input bit f, input bit l, input logic [5:0][7:0] ln);
        @(negedge clk);
        vld_in   = v;
        first_in = f;
        last_in  = l;
        data_in  = ln;
        if (v) model_beat(f, l, ln);
    endtask

    function automatic logic [5:0][7:0] rand_lanes();
        logic [5:0][7:0] ln;
        for (int k = 0; k < 6; k++) ln[k] = 8'($urandom_range(255));
        return ln;
    endfunction

    function automatic logic [5:0][7:0] fill_lanes(input int v);
        logic [5:0][7:0] ln;
        for (int k = 0; k < 6; k++) ln[k] = 8'(v);
        return ln;
    endfunction

    // Lanes 0..4 small random, lane 5 makes the six-lane total equal v.
    function automatic logic [5:0][7:0] sum_lanes(input int v);
        logic [5:0][7:0] ln;
        int acc;
        int r;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            r = int'($urandom_range(40)) - 20;
            ln[k] = 8'(r);
            acc = acc + r;
        end
        ln[5] = 8'(v - acc);
        return ln;
    endfunction

    // Bubbles carry junk first/last/data, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), rand_lanes());
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset  = 1'b1;
        vld_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            m_acc[c] = 0;
            m_ovf[c] = 1'b0;
        end
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor ----------------------------------------------------------

    task automatic check_out(input int idx, input string nm, input logic v, input longint d, input logic o);
        logic [63:0] e;
        bit          have;
        longint      exp_d;
        logic        exp_o;
        int          exp_c;
        if (v !== 1'b1) return;
        have = 1'b0;
        e    = '0;
        case (idx)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            2: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
            3: if (exp_q3.size() > 0) begin e = exp_q3.pop_front(); have = 1'b1; end
            default: if (exp_q4.size() > 0) begin e = exp_q4.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL %s unexpected pulse: got data=%0d ovf=%0b at cycle %0d, required no pulse", nm, d, o, cyc);
            return;
        end
        exp_d = longint'($signed(e[31:0]));
        exp_o = e[32];
        exp_c = int'(e[63:33]);
        if (d !== exp_d || o !== exp_o || cyc != exp_c) begin
            failures++;
            $display("FAIL %s frame: got data=%0d ovf=%0b cycle=%0d, required data=%0d ovf=%0b cycle=%0d",
                     nm, d, o, cyc, exp_d, exp_o, exp_c);
        end
    endtask

    always @(negedge clk) check_out(0, "n6_o16_sat",  v0, longint'($signed(d0)), o0);
    always @(negedge clk) check_out(1, "n6_o12_sat",  v1, longint'($signed(d1)), o1);
    always @(negedge clk) check_out(2, "n6_o12_wrap", v2, longint'($signed(d2)), o2);
    always @(negedge clk) check_out(3, "n1_o16_sat",  v3, longint'($signed(d3)), o3);
    always @(negedge clk) check_out(4, "n5_o16_sat",  v4, longint'($signed(d4)), o4);

    task automatic check_reset(input string nm, input logic v, input longint d, input logic o);
        checks++;
        if (v !== 1'b0 || d !== 0 || o !== 1'b0) begin
            failures++;
            $display("FAIL %s reset state: got vld=%0b data=%0d ovf=%0b, required vld=0 data=0 ovf=0", nm, v, d, o);
        end
    endtask

    task automatic check_drained(input string nm, input int pending);
        checks++;
        if (pending != 0) begin
            failures++;
            $display("FAIL %s drain: got %0d frames still expected, required 0", nm, pending);
        end
    endtask

    // Stimulus --------------------------------------------------------------------

    initial begin
        logic [5:0][7:0] ln;
        int len;
        bit use_first;

        reset    = 1'b1;
        vld_in   = 1'b0;
        first_in = 1'b0;
        last_in  = 1'b0;
        data_in  = '0;
        for (int c = 0; c < 5; c++) begin
            m_acc[c] = 0;
            m_ovf[c] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset("n6_o16_sat",  v0, longint'($signed(d0)), o0);
        check_reset("n6_o12_sat",  v1, longint'($signed(d1)), o1);
        check_reset("n6_o12_wrap", v2, longint'($signed(d2)), o2);
        check_reset("n1_o16_sat",  v3, longint'($signed(d3)), o3);
        check_reset("n5_o16_sat",  v4, longint'($signed(d4)), o4);
        reset = 1'b0;

        // Single-beat frame, lanes 1..6.
        for (int k = 0; k < 6; k++) ln[k] = 8'(k + 1);
        drive(1'b1, 1'b1, 1'b1, ln);
        idle(6);

        // Four beats of -128 with bubbles in between.
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, b == 0, b == 3, fill_lanes(-128));
            idle(int'($urandom_range(2, 1)));
        end
        idle(6);

        // Eight full-rate beats of +127: overflows the 12-bit builds.
        for (int b = 0; b < 8; b++) drive(1'b1, b == 0, b == 7, fill_lanes(127));
        idle(6);

        // Back-to-back frames {10,20} then {-5}.
        drive(1'b1, 1'b1, 1'b0, sum_lanes(10));
        drive(1'b1, 1'b0, 1'b1, sum_lanes(20));
        drive(1'b1, 1'b1, 1'b1, sum_lanes(-5));
        idle(6);

        // Reset with a partly accumulated frame and beats still in the tree.
        for (int b = 0; b < 5; b++) drive(1'b1, b == 0, 1'b0, rand_lanes());
        apply_reset(2);
        drive(1'b1, 1'b0, 1'b1, sum_lanes(7));
        idle(6);
        drive(1'b1, 1'b1, 1'b1, sum_lanes(7));
        idle(6);

        // Random frames, some without first, random bubbles, random lane values.
        for (int f = 0; f < 40; f++) begin
            len       = int'($urandom_range(5, 1));
            use_first = ($urandom_range(3) != 0);
            for (int b = 0; b < len; b++) begin
                drive(1'b1, (b == 0) && use_first, b == len - 1, rand_lanes());
                if ($urandom_range(2) == 0) idle(int'($urandom_range(2, 1)));
            end
        end
        idle(10);

        check_drained("n6_o16_sat",  exp_q0.size());
        check_drained("n6_o12_sat",  exp_q1.size());
        check_drained("n6_o12_wrap", exp_q2.size());
        check_drained("n1_o16_sat",  exp_q3.size());
        check_drained("n5_o16_sat",  exp_q4.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
